pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register; successor to the fixed per-field MEM/WB-style stage registers.
//  - Carries one packed payload word between two stages using a valid/ready handshake.
//  - A 2-entry skid buffer keeps full throughput under back-pressure. in_ready is driven from a register.
//  - Supports whole-stage flush.
//  - Supports per-transfer kill, which clears the payload's write-enable bit (stall/squash handling).

---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and per-transfer kill.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
   parameter int unsigned           DATA_W  = 64,
   parameter int unsigned           WEN_BIT = 0,
   parameter logic [DATA_W-1:0]     RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_kill,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       stall_cnt
);

   // Encoding is {skid_valid, main_valid}, so both handshake outputs come straight from flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [DATA_W-1:0] word_s;
   logic              accept_s;
   logic              drain_s;

   assign in_ready  = ~state_q[1];
   assign out_valid = state_q[0];
   assign out_data  = main_q;
   assign accept_s  = in_valid & ~state_q[1];
   assign drain_s   = state_q[0] & out_ready;

   // Incoming word with the write-enable bit squashed by kill.
   always_comb begin
      word_s          = in_data;
      word_s[WEN_BIT] = in_data[WEN_BIT] & ~in_kill;
   end

   // Next-state and payload routing; flush overrides any accept or drain.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = RST_VAL;
         skid_d  = RST_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_s) begin
                  state_d = ONE;
                  main_d  = word_s;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && drain_s) begin
                  state_d = ONE;
                  main_d  = word_s;
               end else if (accept_s) begin
                  state_d = FULL;
                  skid_d  = word_s;
               end else if (drain_s) begin
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            FULL: begin
               if (drain_s) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = RST_VAL;
               end else begin
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = RST_VAL;
               skid_d  = RST_VAL;
            end
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Saturating stall counter; flush deliberately leaves it alone.
   always_comb begin
      if (state_q[0] && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus randomised check of pipe_stage_skid against a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_stage_skid;

   localparam int unsigned       DW   = 16;
   localparam int unsigned       WEN  = 0;
   localparam logic [DW-1:0]     RSTV = 16'h5A5A;
`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_kill;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [31:0]   stall_cnt;

   logic [DW-1:0] sb_q[$];
   int            errors;
   int            checks;
   int unsigned   exp_stall;
   bit            last_acc;

   pipe_stage_skid #(.DATA_W(DW), .WEN_BIT(WEN), .RST_VAL(RSTV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_kill   (in_kill),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: check state at negedge, update model, advance to just after posedge.
   task automatic step();
      int            n;
      logic [DW-1:0] w;
      logic [DW-1:0] e;
      @(negedge clk);
      n = sb_q.size();
      chk("out_valid", {31'd0, out_valid}, {31'd0, (n > 0)});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (n < 2)});
      chk("stall_cnt", stall_cnt, PERF ? exp_stall : 32'd0);
      if (n > 0 && out_ready) begin
         e = sb_q.pop_front();
         chk("out_data", {16'd0, out_data}, {16'd0, e});
      end
      if (n > 0 && !out_ready) exp_stall++;
      last_acc = in_valid && (n < 2);
      if (flush) begin
         sb_q.delete();
      end else if (last_acc) begin
         w      = in_data;
         w[WEN] = in_data[WEN] & ~in_kill;
         sb_q.push_back(w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [DW-1:0] d, input logic k, input logic ordy);
      in_valid  = 1'b1;
      in_data   = d;
      in_kill   = k;
      out_ready = ordy;
      step();
   endtask

   task automatic idle(input logic ordy, input int cycles);
      in_valid  = 1'b0;
      in_kill   = 1'b0;
      out_ready = ordy;
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      exp_stall = 0;
      last_acc  = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_kill   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", {16'd0, out_data}, {16'd0, RSTV});
      chk("rst_stall", stall_cnt, 32'd0);
      rst_n = 1'b1;

      // T1 pass-through
      offer(16'h0011, 1'b0, 1'b1);
      offer(16'h0022, 1'b0, 1'b1);
      offer(16'h0033, 1'b0, 1'b1);
      idle(1'b1, 2);

      // T2 back-pressure into the skid entry
      offer(16'h0011, 1'b0, 1'b0);
      offer(16'h0022, 1'b0, 1'b0);
      idle(1'b0, 2);
      chk("t2_hold", {16'd0, out_data}, 32'h0000_0011);
      idle(1'b1, 3);

      // T3 kill, then kill held while not accepted
      offer(16'h00FF, 1'b1, 1'b1);
      offer(16'h00FF, 1'b0, 1'b1);
      idle(1'b1, 2);
      offer(16'h0101, 1'b0, 1'b0);
      offer(16'h0203, 1'b0, 1'b0);
      offer(16'h0305, 1'b1, 1'b0);
      offer(16'h0305, 1'b0, 1'b1);
      offer(16'h0305, 1'b0, 1'b1);
      idle(1'b1, 3);

      // T4 flush while FULL, then flush coincident with a drain
      offer(16'h0001, 1'b0, 1'b0);
      offer(16'h0002, 1'b0, 1'b0);
      flush = 1'b1;
      offer(16'h0044, 1'b0, 1'b0);
      flush = 1'b0;
      chk("t4_flush_data", {16'd0, out_data}, {16'd0, RSTV});
      idle(1'b1, 2);
      offer(16'h0055, 1'b0, 1'b1);
      flush = 1'b1;
      offer(16'h0066, 1'b0, 1'b1);
      flush = 1'b0;
      idle(1'b1, 2);

      // T5 asynchronous reset mid-cycle while FULL
      offer(16'h0088, 1'b0, 1'b0);
      offer(16'h0099, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_out_data", {16'd0, out_data}, {16'd0, RSTV});
      chk("t5_stall", stall_cnt, 32'd0);
      sb_q.delete();
      exp_stall = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // T6 stall counting
      offer(16'h0077, 1'b0, 1'b0);
      idle(1'b0, 5);
      chk("t6_stall", stall_cnt, PERF ? 32'd5 : 32'd0);
      idle(1'b1, 2);

      // Random traffic; a word that was not accepted is held on the input
      in_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            in_kill  = ($urandom_range(0, 3) == 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // Drain whatever is left, within a bounded number of cycles
      in_valid = 1'b0;
      for (int i = 0; i < 8 && sb_q.size() > 0; i++) idle(1'b1, 1);
      chk("final_drained", sb_q.size(), 32'd0);
      idle(1'b1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
